// File: rtl/rvcore_insn_line_buffer_if.sv
// Request/acknowledge line port shared by the core fetch side and the memory fill side.
// The master drives req/addr and holds them until the slave pulses ack with a 128-bit line.
interface rvcore_insn_line_buffer_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [127:0]      data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/rvcore_insn_line_buffer.sv
// Fully-associative instruction line buffer with round-robin replacement and snoop/flush coherence.
// Optional hit/miss counters are built when RVCORE_LBUF_STATS_EN is defined.
//
// state | meaning
// IDLE  | accept lookups; hits answer the next cycle
// FILL  | m_req held, waiting for the line from memory
// RESP  | returning the filled line to the core
module rvcore_insn_line_buffer #(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 32
) (
  input  logic                     CLK,
  input  logic                     RST_X,
  rvcore_insn_line_buffer_if.slave  core,
  rvcore_insn_line_buffer_if.master mem,
  input  logic                     inv_valid,
  input  logic [ADDR_W-1:0]        inv_addr,
  input  logic                     flush
`ifdef RVCORE_LBUF_STATS_EN
  ,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
`endif
);

  localparam int RR_W  = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t              state_q, state_d;
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q  [ENTRIES];
  logic [127:0]        line_q [ENTRIES];
  logic [RR_W-1:0]     rr_q;
  logic                stale_q;
  logic                ack_q;
  logic [127:0]        data_q;
  logic                mreq_q;
  logic [ADDR_W-1:0]   maddr_q;

  logic [TAG_W-1:0]    c_tag, inv_tag;
  logic                hit;
  logic [RR_W-1:0]     hit_idx;
  logic                lookup, do_hit, do_miss, fill_done, inv_fill_hit, fill_stale;

  assign c_tag   = core.addr[ADDR_W-1:4];
  assign inv_tag = inv_addr[ADDR_W-1:4];

  logic unused_low_bits;
  assign unused_low_bits = ^{core.addr[3:0], inv_addr[3:0]};

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == c_tag) begin
        hit     = 1'b1;
        hit_idx = RR_W'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_miss) state_d = FILL;
      FILL:    if (mem.ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ack_q blocks a second lookup while the core is still holding the request it just got answered.
  always_comb begin
    lookup       = (state_q == IDLE) && core.req && !ack_q;
    do_hit       = lookup && hit;
    do_miss      = lookup && !hit;
    fill_done    = (state_q == FILL) && mem.ack;
    inv_fill_hit = inv_valid && (inv_tag == maddr_q[ADDR_W-1:4]);
    fill_stale   = stale_q || flush || inv_fill_hit;
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      ack_q   <= 1'b0;
      data_q  <= '0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
      stale_q <= 1'b0;
      rr_q    <= '0;
      valid_q <= '0;
    end else begin
      ack_q  <= do_hit || fill_done;
      mreq_q <= (state_d == FILL);
      if (do_hit)         data_q <= line_q[hit_idx];
      else if (fill_done) data_q <= mem.data;
      if (do_miss) begin
        maddr_q <= {c_tag, 4'b0};
        stale_q <= 1'b0;
      end else if (state_q == FILL && (flush || inv_fill_hit)) begin
        stale_q <= 1'b1;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush || (inv_valid && tag_q[i] == inv_tag)) valid_q[i] <= 1'b0;
      end
      // A fill raced by a snoop still evicts its victim but is never installed.
      if (fill_done) begin
        valid_q[rr_q] <= !fill_stale;
        rr_q          <= rr_q + RR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_X && fill_done) begin
      tag_q[rr_q]  <= maddr_q[ADDR_W-1:4];
      line_q[rr_q] <= mem.data;
    end
  end

  assign core.ack  = ack_q;
  assign core.data = data_q;
  assign mem.req   = mreq_q;
  assign mem.addr  = maddr_q;

`ifdef RVCORE_LBUF_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (do_hit && hit_cnt != 32'hFFFF_FFFF)   hit_cnt  <= hit_cnt + 32'd1;
      if (do_miss && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvcore_insn_line_buffer.sv
// Directed and randomized fetch traffic checked against an array model of the line buffer.
module tb_rvcore_insn_line_buffer;
  localparam int ENTRIES = 4;

  logic        CLK;
  logic        RST_X;
  logic        inv_valid;
  logic [31:0] inv_addr;
  logic        flush;
`ifdef RVCORE_LBUF_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  rvcore_insn_line_buffer_if #(.ADDR_W(32)) cif ();
  rvcore_insn_line_buffer_if #(.ADDR_W(32)) mif ();

  rvcore_insn_line_buffer #(.ENTRIES(ENTRIES), .ADDR_W(32)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .core      (cif),
    .mem       (mif),
    .inv_valid (inv_valid),
    .inv_addr  (inv_addr),
    .flush     (flush)
`ifdef RVCORE_LBUF_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_hit  = 0;
  int n_miss = 0;

  // Reference model: one slot per entry plus the replacement pointer.
  logic         mv [ENTRIES];
  logic [27:0]  mt [ENTRIES];
  logic [127:0] ml [ENTRIES];
  int           mrr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int model_lookup(input logic [31:0] a);
    for (int i = 0; i < ENTRIES; i++)
      if (mv[i] && mt[i] == a[31:4]) return i;
    return -1;
  endfunction

  function automatic void model_inv(input logic [31:0] a);
    for (int i = 0; i < ENTRIES; i++)
      if (mv[i] && mt[i] == a[31:4]) mv[i] = 1'b0;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    RST_X = 1'b0; cif.req = 1'b0; mif.ack = 1'b0; inv_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    model_flush();
    mrr = 0; n_hit = 0; n_miss = 0;
  endtask

  task automatic drive_snoop(input bit is_flush, input logic [31:0] sa);
    if (is_flush) flush = 1'b1;
    else begin inv_valid = 1'b1; inv_addr = sa; end
  endtask

  // Applies a snoop to the model; returns 1 when it hits the line being filled.
  function automatic bit model_snoop(input bit is_flush, input logic [31:0] sa, input logic [31:0] fa);
    if (is_flush) begin model_flush(); return 1'b1; end
    model_inv(sa);
    return sa[31:4] == fa[31:4];
  endfunction

  // mode: 0 none, 1 inv in FILL, 2 flush in FILL, 3 inv with m_ack, 4 flush with m_ack,
  //       5 inv at lookup, 6 flush at lookup
  task automatic fetch(input logic [31:0] a, input int lat, input int mode_in, input logic [31:0] sa);
    int idx, mode;
    bit stale;
    logic [127:0] d;
    mode = mode_in;
    idx = model_lookup(a);
    cif.req = 1'b1; cif.addr = a;
    if (mode == 5 || mode == 6) drive_snoop(mode == 6, sa);
    @(negedge CLK);
    inv_valid = 1'b0; flush = 1'b0;
    if (idx >= 0) begin
      check("hit_ack", cif.ack, 1);
      check("hit_data", cif.data, ml[idx]);
      check("hit_no_mreq", mif.req, 0);
      n_hit++;
      if (mode == 5 || mode == 6) void'(model_snoop(mode == 6, sa, a));
      cif.req = 1'b0;
      @(negedge CLK);
      check("hit_ack_pulse", cif.ack, 0);
    end else begin
      if (mode == 5 || mode == 6) void'(model_snoop(mode == 6, sa, a));
      check("miss_no_ack", cif.ack, 0);
      check("miss_mreq", mif.req, 1);
      check("miss_maddr", mif.addr, {a[31:4], 4'h0});
      n_miss++;
      stale = 1'b0;
      if (lat == 0 && (mode == 1 || mode == 2)) mode = mode + 2;
      for (int i = 0; i < lat; i++) begin
        if (i == 0 && (mode == 1 || mode == 2)) drive_snoop(mode == 2, sa);
        @(negedge CLK);
        inv_valid = 1'b0; flush = 1'b0;
        if (i == 0 && (mode == 1 || mode == 2)) stale |= model_snoop(mode == 2, sa, a);
        check("fill_hold_mreq", mif.req, 1);
        check("fill_no_ack", cif.ack, 0);
      end
      d = rand_line();
      mif.ack = 1'b1; mif.data = d;
      if (mode == 3 || mode == 4) drive_snoop(mode == 4, sa);
      @(negedge CLK);
      mif.ack = 1'b0; mif.data = rand_line(); inv_valid = 1'b0; flush = 1'b0;
      if (mode == 3 || mode == 4) stale |= model_snoop(mode == 4, sa, a);
      mv[mrr] = !stale; mt[mrr] = a[31:4]; ml[mrr] = d;
      mrr = (mrr + 1) % ENTRIES;
      check("resp_ack", cif.ack, 1);
      check("resp_data", cif.data, d);
      check("resp_mreq_drop", mif.req, 0);
      cif.req = 1'b0;
      @(negedge CLK);
      check("resp_ack_pulse", cif.ack, 0);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    model_flush();
  endtask

  initial begin
    logic [31:0] a, sa;
    int m;
    RST_X = 1'b0; cif.req = 1'b0; cif.addr = '0; mif.ack = 1'b0; mif.data = '0;
    inv_valid = 1'b0; inv_addr = '0; flush = 1'b0;
    mrr = 0;
    for (int i = 0; i < ENTRIES; i++) begin mv[i] = 1'b0; mt[i] = '0; ml[i] = '0; end
    do_reset();
    check("reset_c_ack", cif.ack, 0);
    check("reset_c_data", cif.data, 0);
    check("reset_m_req", mif.req, 0);
    check("reset_m_addr", mif.addr, 0);

    // T1 cold miss, T2 hit on the same line
    fetch(32'h8000_0004, 2, 0, 0);
    fetch(32'h8000_000C, 0, 0, 0);
`ifdef RVCORE_LBUF_STATS_EN
    check("t6_hit_cnt", hit_cnt, 1);
    check("t6_miss_cnt", miss_cnt, 1);
    pulse_flush();
    check("t6_hit_cnt_flush", hit_cnt, 1);
    check("t6_miss_cnt_flush", miss_cnt, 1);
`endif

    // m_ack while idle must not produce a response
    mif.ack = 1'b1; mif.data = rand_line();
    @(negedge CLK);
    mif.ack = 1'b0;
    check("stray_mack_ack", cif.ack, 0);
    check("stray_mack_mreq", mif.req, 0);

    // T3 replacement wrap from a clean pointer
    do_reset();
    for (int i = 0; i < 5; i++) fetch(32'h0000_1000 + 32'(i * 16), i % 2, 0, 0);
    fetch(32'h0000_1010, 0, 0, 0);
    fetch(32'h0000_1000, 1, 0, 0);

    // T4 invalidate racing a fill, then refetch misses
    fetch(32'h0000_2000, 2, 1, 32'h0000_2008);
    fetch(32'h0000_2000, 1, 0, 0);
    // hit with simultaneous invalidate returns old data, then the line is gone
    fetch(32'h0000_2000, 0, 5, 32'h0000_2004);
    fetch(32'h0000_2000, 0, 0, 0);
    fetch(32'h0000_2010, 1, 4, 0);
    fetch(32'h0000_2010, 0, 0, 0);

    // T5 flush, then reset during FILL with a late m_ack
    fetch(32'h0000_4000, 0, 0, 0);
    fetch(32'h0000_4010, 1, 0, 0);
    fetch(32'h0000_4020, 0, 0, 0);
    pulse_flush();
    fetch(32'h0000_4000, 0, 0, 0);
    fetch(32'h0000_4010, 0, 0, 0);
    fetch(32'h0000_4020, 0, 0, 0);

    cif.req = 1'b1; cif.addr = 32'h0000_5000;
    @(negedge CLK);
    check("t5_pre_rst_mreq", mif.req, 1);
    RST_X = 1'b0; cif.req = 1'b0;
    @(negedge CLK);
    RST_X = 1'b1;
    mif.ack = 1'b1; mif.data = rand_line();
    check("t5_rst_mreq", mif.req, 0);
    check("t5_rst_ack", cif.ack, 0);
    @(negedge CLK);
    mif.ack = 1'b0;
    check("t5_late_mack_ack", cif.ack, 0);
    check("t5_late_mack_mreq", mif.req, 0);
    check("t5_rst_data", cif.data, 0);
    model_flush(); mrr = 0; n_hit = 0; n_miss = 0;
    fetch(32'h0000_4000, 1, 0, 0);

    // randomized traffic over 8 lines so hits, evictions and snoops mix
    for (int n = 0; n < 200; n++) begin
      a  = 32'h0000_3000 + (32'($urandom_range(0, 7)) << 4) + 32'($urandom_range(0, 15));
      sa = ($urandom_range(0, 1) == 1) ? a
           : 32'h0000_3000 + (32'($urandom_range(0, 7)) << 4) + 32'($urandom_range(0, 15));
      m  = $urandom_range(0, 12);
      fetch(a, $urandom_range(0, 3), (m > 6) ? 0 : m, sa);
    end
`ifdef RVCORE_LBUF_STATS_EN
    check("final_hit_cnt", hit_cnt, 32'(n_hit));
    check("final_miss_cnt", miss_cnt, 32'(n_miss));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
